// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle datapath controller.
//   - opcode constants (IR[15:12])
//   - ALU control encodings and ALU-B mux selects
//   - FSM state enum and the registered control-word struct
//   - moore_ctrl(): control word for a given state
package multicycle_controller_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  localparam logic [1:0] ALUB_REGB   = 2'b00;
  localparam logic [1:0] ALUB_TWO    = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, HALT
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  // Control word held while in state s. alu_r is the R-type ALU op,
  // only consulted for EXEC_R.
  function automatic ctrl_t moore_ctrl(state_e s, logic [3:0] alu_r);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (s)
      IDLE:     c.alu_control = 4'b0000;
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = ALUB_TWO;
      end
      DECODE:   c.alu_src_b = ALUB_IMM_SH;
      EXEC_R: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = ALUB_REGB;
        c.alu_control = alu_r;
      end
      WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_IMM;
      end
      WB_I:     c.reg_write = 1'b1;
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = ALUB_REGB;
        c.alu_control = ALU_SUB;
        c.pc_src      = 1'b1;
      end
      HALT:     c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decode.sv
// mc_alu_decode: combinational R-type opcode -> ALU control.
//   opcode_i       [3:0]  IR[15:12]
//   alu_control_o  [3:0]  ALU op; add for anything that is not R-type
module mc_alu_decode
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (opcode_i)
      OP_ADD:  alu_control_o = ALU_ADD;
      OP_SUB:  alu_control_o = ALU_SUB;
      OP_AND:  alu_control_o = ALU_AND;
      OP_OR:   alu_control_o = ALU_OR;
      OP_NOR:  alu_control_o = ALU_NOR;
      OP_NAND: alu_control_o = ALU_NAND;
      OP_SLT:  alu_control_o = ALU_SLT;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 16-bit datapath.
// Inputs : clock, reset_n (sync, active low), run, opcode, zero, mem_ready.
// Outputs: memory port (mem_req, mem_we, iord), IR/PC loads (ir_write,
//          pc_write, pc_src), ALU selects (alu_src_a, alu_src_b,
//          alu_control), register file (reg_write, reg_dst, mem_to_reg),
//          status (halted, illegal_op, retired).
//
// state    | meaning
// IDLE     | waiting for run
// FETCH    | read instruction at PC, PC += 2 on mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// EXEC_R   | reg A op reg B
// WB_R     | write ALUOut to IR[7:6]
// EXEC_I   | reg A + sext imm
// WB_I     | write ALUOut to IR[9:8]
// MEM_ADDR | reg A + sext imm as data address
// MEM_RD   | data read at ALUOut, wait for mem_ready
// WB_MEM   | write MDR to IR[9:8]
// MEM_WR   | data write at ALUOut, wait for mem_ready
// BRANCH   | compare, load PC from ALUOut if taken
// HALT     | terminal until reset
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       alu_r;
  logic             retire;
  logic             fetch_done;
  logic             br_taken;

  mc_alu_decode u_alu_decode (
    .opcode_i      (opcode),
    .alu_control_o (alu_r)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_NOR, OP_NAND, OP_SLT: state_d = EXEC_R;
          OP_ADDI:                 state_d = EXEC_I;
          OP_LW, OP_SW:            state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:          state_d = BRANCH;
          OP_HALT: begin
            state_d = HALT;
            retire  = 1'b1;
          end
          default:                 state_d = FETCH;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_R, WB_I, WB_MEM, BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  // The control word is registered from the next state, so outputs are
  // glitch-free and valid from the first cycle of each state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d, alu_r);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // IR/PC loads depend on this cycle's mem_ready / zero and cannot be
  // registered without adding a cycle of latency.
  assign fetch_done = (state_q == FETCH) && mem_ready;
  assign br_taken   = (state_q == BRANCH) &&
                      (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));

  assign ir_write    = fetch_done;
  assign pc_write    = fetch_done || br_taken;
  assign illegal_op  = (state_q == DECODE) && (opcode >= 4'hC) && (opcode <= 4'hE);

  assign mem_req     = ctrl_q.mem_req;
  assign mem_we      = ctrl_q.mem_we;
  assign iord        = ctrl_q.iord;
  assign pc_src      = ctrl_q.pc_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = ctrl_q.alu_control;
  assign reg_write   = ctrl_q.reg_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign halted      = ctrl_q.halted;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances share all inputs: one with
// the default counter width and one with CNT_W = 3 to exercise wrap.
// Expected per-cycle outputs are generated from an instruction-level
// description (opcode, fetch waits, data waits, zero flag).
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic clock = 1'b0;
  logic reset_n, run, zero, mem_ready;
  logic [3:0] opcode;

  always #5 clock = ~clock;

  logic a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_pc_src, a_alu_src_a;
  logic [1:0] a_alu_src_b;
  logic [3:0] a_alu_control;
  logic a_reg_write, a_reg_dst, a_mem_to_reg, a_halted, a_illegal_op;
  logic [15:0] a_retired;

  logic b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_pc_src, b_alu_src_a;
  logic [1:0] b_alu_src_b;
  logic [3:0] b_alu_control;
  logic b_reg_write, b_reg_dst, b_mem_to_reg, b_halted, b_illegal_op;
  logic [2:0] b_retired;

  multicycle_controller #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_control(a_alu_control),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .halted(a_halted), .illegal_op(a_illegal_op), .retired(a_retired));

  multicycle_controller #(.CNT_W(3)) dut_w (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_control(b_alu_control),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .halted(b_halted), .illegal_op(b_illegal_op), .retired(b_retired));

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       reg_write, reg_dst, mem_to_reg, halted, illegal;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       rdy;
    logic       ret;
    outs_t      exp;
  } cyc_t;

  typedef struct {
    logic  rst_n;
    logic  run;
    outs_t exp;
  } tab_t;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt      = 0;
  logic [3:0] r_alu [0:6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1101, 4'b0111};

  function automatic outs_t outs_a();
    return '{a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_pc_src, a_alu_src_a,
             a_alu_src_b, a_alu_control, a_reg_write, a_reg_dst, a_mem_to_reg,
             a_halted, a_illegal_op};
  endfunction

  function automatic outs_t outs_b();
    return '{b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_pc_src, b_alu_src_a,
             b_alu_src_b, b_alu_control, b_reg_write, b_reg_dst, b_mem_to_reg,
             b_halted, b_illegal_op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.alu_ctl = 4'b0010;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] op, input logic z, input outs_t o,
                      input logic rdy, input logic ret);
    cyc_t c;
    c.op = op; c.z = z; c.exp = o; c.rdy = rdy; c.ret = ret;
    q.push_back(c);
  endtask

  // One instruction, starting with its first FETCH cycle.
  task automatic expand(input logic [3:0] op, input int fw, input int dw, input logic z);
    outs_t o;
    for (int i = 0; i <= fw; i++) begin
      o = base();
      o.mem_req = 1'b1; o.alu_src_b = 2'b01;
      o.ir_write = (i == fw); o.pc_write = (i == fw);
      push(op, z, o, (i == fw), 1'b0);
    end
    o = base();
    o.alu_src_b = 2'b11;
    o.illegal = (op >= 4'hC) && (op <= 4'hE);
    push(op, z, o, rnd(), op == 4'hF);
    if (op <= 4'h6) begin
      o = base(); o.alu_src_a = 1'b1; o.alu_ctl = r_alu[op];
      push(op, z, o, rnd(), 1'b0);
      o = base(); o.reg_write = 1'b1; o.reg_dst = 1'b1;
      push(op, z, o, rnd(), 1'b1);
    end else if (op == 4'h7) begin
      o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      push(op, z, o, rnd(), 1'b0);
      o = base(); o.reg_write = 1'b1;
      push(op, z, o, rnd(), 1'b1);
    end else if (op == 4'h8 || op == 4'h9) begin
      o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      push(op, z, o, rnd(), 1'b0);
      for (int i = 0; i <= dw; i++) begin
        o = base(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == 4'h9);
        push(op, z, o, (i == dw), (op == 4'h9) && (i == dw));
      end
      if (op == 4'h8) begin
        o = base(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        push(op, z, o, rnd(), 1'b1);
      end
    end else if (op == 4'hA || op == 4'hB) begin
      o = base(); o.alu_src_a = 1'b1; o.alu_ctl = 4'b0110; o.pc_src = 1'b1;
      o.pc_write = (op == 4'hA) ? z : !z;
      push(op, z, o, rnd(), 1'b1);
    end
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      cyc_t c;
      c = q.pop_front();
      reset_n = 1'b1; run = 1'b1;
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      check("outs", outs_a(), c.exp);
      check("outs_w", outs_b(), c.exp);
      check("retired", a_retired, cnt[15:0]);
      check("retired_w", b_retired, cnt[2:0]);
      if (c.ret) cnt++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab_t  tab [8];
    outs_t o_fetch;
    int    nops;
    logic [3:0] op;

    o_fetch = base(); o_fetch.mem_req = 1'b1; o_fetch.alu_src_b = 2'b01;
    tab[0] = '{1'b0, 1'b0, outs_t'(0)};
    tab[1] = '{1'b0, 1'b0, outs_t'(0)};
    for (int i = 2; i < 7; i++) tab[i] = '{1'b1, 1'b0, outs_t'(0)};
    tab[7] = '{1'b1, 1'b1, o_fetch};

    reset_n = 1'b0; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;

    // Reset, idle with run low, then start.
    for (int i = 0; i < 8; i++) begin
      reset_n = tab[i].rst_n; run = tab[i].run; mem_ready = 1'b0;
      @(posedge clock); #1;
      check("idle_tab", outs_a(), tab[i].exp);
      check("idle_tab_w", outs_b(), tab[i].exp);
      check("idle_retired", a_retired, 16'd0);
    end

    // Directed: add, lw with 3 data waits, bne/beq not-zero, illegal, halt.
    expand(4'h0, 0, 0, 1'b0);
    expand(4'h8, 0, 3, 1'b1);
    expand(4'hB, 0, 0, 1'b0);
    expand(4'hA, 0, 0, 1'b0);
    expand(4'hD, 0, 0, 1'b0);
    expand(4'hF, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      outs_t o;
      o = base(); o.halted = 1'b1;
      push(4'($urandom_range(0, 15)), rnd(), o, rnd(), 1'b0);
    end
    run_q();
    check("halt_count", a_retired, 16'd5);

    reset_n = 1'b0; run = 1'b1;
    @(posedge clock); #1;
    cnt = 0;
    check("halt_cleared", outs_a(), 64'd0);
    check("halt_cleared_cnt", a_retired, 16'd0);

    // Random program with random wait states.
    push(4'h0, 1'b0, outs_t'(0), rnd(), 1'b0);
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 14));
      expand(op, ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3)),
                 ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3)), rnd());
    end
    run_q();

    // Reset while a fetch is waiting on memory.
    reset_n = 1'b1; run = 1'b1; mem_ready = 1'b0;
    @(posedge clock); #1;
    check("fetch_wait_req", a_mem_req, 1'b1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    cnt = 0;
    check("rst_mid_fetch", outs_a(), 64'd0);
    check("rst_mid_fetch_cnt", a_retired, 16'd0);

    // Counter wrap on the narrow instance.
    push(4'h0, 1'b0, outs_t'(0), 1'b0, 1'b0);
    nops = 9;
    for (int n = 0; n < nops; n++) expand(4'h0, 0, 0, rnd());
    run_q();
    check("wrap_w", b_retired, 3'd1);
    check("wrap_full", a_retired, 16'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
